// File: rtl/fetch_dec_queue.sv
// Multi-lane fetch-to-decode instruction queue (circular buffer, LANES in / LANES out per cycle).
// Latency: one cycle enqueue-to-visible; FETCH_DEC_QUEUE_BYPASS_EN adds a same-cycle path when empty.
// Backpressure: in_ready drops unless a full LANES group fits; consumer pops 0..LANES via out_accept.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_dec_queue #(
    parameter int ADDR  = `AddrWidth,
    parameter int INST  = `InstWidth,
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*ADDR-1:0]      in_pc,
    input  logic [LANES*INST-1:0]      in_inst,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*ADDR-1:0]      out_pc,
    output logic [LANES*INST-1:0]      out_inst,
    input  logic [$clog2(LANES+1)-1:0] out_accept,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);
    localparam int CW = $clog2(LANES+1);

    logic [ADDR-1:0]  r_pc   [DEPTH];
    logic [INST-1:0]  r_inst [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [NW-1:0]    r_count;

    logic [CW-1:0]    w_k;
    logic [CW-1:0]    w_enq_k;
    logic [CW-1:0]    w_wr_lo;
    logic [CW-1:0]    w_out_cnt;
    logic             w_ready;
    logic             w_byp;
    logic [LANES-1:0] w_wr_en;

    always_comb begin
        w_k = '0;
        for (int i = 0; i < LANES; i++) begin
            w_k = w_k + CW'(in_valid[i]);
        end
    end

    assign w_ready = (DEPTH - int'(r_count)) >= LANES;

`ifdef FETCH_DEC_QUEUE_BYPASS_EN
    assign w_byp = reset_ && (r_count == '0) && !flush && (in_valid != '0);
`else
    assign w_byp = 1'b0;
`endif

    // Bypassed lanes already consumed downstream are never written; the rest land at the new head.
    always_comb begin
        w_enq_k = w_ready ? w_k : '0;
        w_wr_lo = w_byp ? out_accept : '0;
        w_wr_en = '0;
        for (int j = 0; j < LANES; j++) begin
            w_wr_en[j] = !flush && (CW'(j) < w_enq_k) && (CW'(j) >= w_wr_lo);
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < LANES; j++) begin
            if (w_wr_en[j]) begin
                r_pc[r_tail + PW'(j)]   <= in_pc[j*ADDR +: ADDR];
                r_inst[r_tail + PW'(j)] <= in_inst[j*INST +: INST];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(out_accept);
            r_tail  <= r_tail + PW'(w_enq_k);
            r_count <= r_count + NW'(w_enq_k) - NW'(out_accept);
        end
    end

    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_inst  = '0;
`ifdef FETCH_DEC_QUEUE_BYPASS_EN
        if (w_byp) begin
            out_valid = in_valid;
            for (int j = 0; j < LANES; j++) begin
                if (in_valid[j]) begin
                    out_pc[j*ADDR +: ADDR]   = in_pc[j*ADDR +: ADDR];
                    out_inst[j*INST +: INST] = in_inst[j*INST +: INST];
                end
            end
        end else
`endif
        begin
            for (int i = 0; i < LANES; i++) begin
                if (NW'(i) < r_count) begin
                    out_valid[i]             = 1'b1;
                    out_pc[i*ADDR +: ADDR]   = r_pc[r_head + PW'(i)];
                    out_inst[i*INST +: INST] = r_inst[r_head + PW'(i)];
                end
            end
        end
    end

    always_comb begin
        w_out_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_out_cnt = w_out_cnt + CW'(out_valid[i]);
        end
    end

    assign in_ready = w_ready;
    assign count    = r_count;

    always @(posedge clk) begin
        if (reset_ && !flush) begin
            assert ((in_valid & (in_valid + 1'b1)) == '0);
            assert (out_accept <= w_out_cnt);
        end
    end
endmodule

// File: tb/tb_fetch_dec_queue.sv
// Bench for fetch_dec_queue (LANES=2, DEPTH=8): directed scenarios plus randomized traffic vs a queue model.
module tb_fetch_dec_queue;
    logic        clk = 1'b0;
    logic        reset_;
    logic [1:0]  in_valid;
    logic [63:0] in_pc;
    logic [63:0] in_inst;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_inst;
    logic [1:0]  out_accept;
    logic        flush;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;
    logic [63:0] mq[$];

    always #5 clk = ~clk;

    fetch_dec_queue #(.ADDR(32), .INST(32), .LANES(2), .DEPTH(8)) dut (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_accept(out_accept), .flush(flush), .count(count)
    );

    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [1:0] a, input logic f);
        in_valid   = v;
        in_pc      = {p1, p0};
        in_inst    = {~p1, ~p0};
        out_accept = a;
        flush      = f;
    endtask

    // Queue model: enqueue a whole group when room for LANES exists, then pop the accepted oldest.
    task automatic tick();
        int k;
        if (flush) begin
            mq.delete();
        end else begin
            k = int'(in_valid[0]) + int'(in_valid[1]);
            if (8 - mq.size() >= 2) begin
                for (int j = 0; j < k; j++) mq.push_back({in_pc[j*32 +: 32], in_inst[j*32 +: 32]});
            end
            for (int j = 0; j < int'(out_accept); j++) begin
                if (mq.size() > 0) void'(mq.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit byp_now();
`ifdef FETCH_DEC_QUEUE_BYPASS_EN
        return reset_ && (mq.size() == 0) && !flush && (in_valid != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] exp_vld();
        if (byp_now()) return in_valid;
        return (mq.size() >= 2) ? 2'b11 : (mq.size() == 1) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [63:0] exp_pc();
        logic [63:0] r = '0;
        for (int j = 0; j < 2; j++) begin
            if (byp_now()) begin
                if (in_valid[j]) r[j*32 +: 32] = in_pc[j*32 +: 32];
            end else if (j < mq.size()) begin
                r[j*32 +: 32] = mq[j][63:32];
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_inst();
        logic [63:0] r = '0;
        for (int j = 0; j < 2; j++) begin
            if (byp_now()) begin
                if (in_valid[j]) r[j*32 +: 32] = in_inst[j*32 +: 32];
            end else if (j < mq.size()) begin
                r[j*32 +: 32] = mq[j][31:0];
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        reset_ = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_vld: got %b expected 00", out_valid); end
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        mq.delete();
    endtask

    task automatic test_first_enqueue();
        drive(2'b11, 32'h100, 32'h104, 2'd0, 1'b0);
        #2;
`ifndef FETCH_DEC_QUEUE_BYPASS_EN
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL first_same_cycle_vld: got %b expected 00", out_valid); end
`endif
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL first_vld: got %b expected 11", out_valid); end
        checks++; if (out_pc[31:0] !== 32'h100) begin errors++; $display("FAIL first_pc0: got %h expected 100", out_pc[31:0]); end
        checks++; if (out_pc[63:32] !== 32'h104) begin errors++; $display("FAIL first_pc1: got %h expected 104", out_pc[63:32]); end
        checks++; if (out_inst[31:0] !== ~32'h100) begin errors++; $display("FAIL first_inst0: got %h expected %h", out_inst[31:0], ~32'h100); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL first_count: got %0d expected 2", count); end
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
        tick();
    endtask

    task automatic test_fill();
        for (int g = 0; g < 5; g++) begin
            drive(2'b11, 32'h200 + 32'(8*g), 32'h204 + 32'(8*g), 2'd0, 1'b0);
            #2;
            checks++;
            if (in_ready !== (g < 4)) begin errors++; $display("FAIL fill_ready g%0d: got %b expected %b", g, in_ready, (g < 4)); end
            tick();
        end
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", count); end
        checks++; if (out_pc[31:0] !== 32'h200) begin errors++; $display("FAIL fill_head: got %h expected 200", out_pc[31:0]); end
        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
        tick();
        drive(2'b11, 32'h900, 32'h904, 2'd0, 1'b0);
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_at7: got %b expected 0", in_ready); end
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL fill_count7: got %0d expected 7", count); end
        for (int i = 0; i < 7; i++) begin
            drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
            #2;
            checks++;
            if (out_pc[31:0] !== 32'h204 + 32'(4*i)) begin
                errors++; $display("FAIL fill_drain%0d: got %h expected %h", i, out_pc[31:0], 32'h204 + 32'(4*i));
            end
            tick();
        end
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL fill_empty: got %0d expected 0", count); end
    endtask

    task automatic test_wrap();
        drive(2'b01, 32'h300, 32'h0, 2'd0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(2'b01, 32'h304 + 32'(4*i), 32'h0, 2'd1, 1'b0);
            #2;
            checks++; if (count !== 4'd1) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 1", i, count); end
            checks++;
            if (out_pc[31:0] !== 32'h300 + 32'(4*i)) begin
                errors++; $display("FAIL wrap_pc%0d: got %h expected %h", i, out_pc[31:0], 32'h300 + 32'(4*i));
            end
            tick();
        end
        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
        tick();
    endtask

    task automatic test_simultaneous();
        drive(2'b11, 32'h400, 32'h404, 2'd0, 1'b0);
        tick();
        drive(2'b01, 32'h408, 32'h0, 2'd0, 1'b0);
        tick();
        drive(2'b11, 32'h40C, 32'h410, 2'd2, 1'b0);
        #2;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL sim_pre_count: got %0d expected 3", count); end
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL sim_count: got %0d expected 3", count); end
        checks++; if (out_pc[31:0] !== 32'h408) begin errors++; $display("FAIL sim_pc0: got %h expected 408", out_pc[31:0]); end
        checks++; if (out_pc[63:32] !== 32'h40C) begin errors++; $display("FAIL sim_pc1: got %h expected 40c", out_pc[63:32]); end
    endtask

    task automatic test_flush();
        drive(2'b01, 32'h500, 32'h0, 2'd1, 1'b0);
        tick();
        drive(2'b11, 32'h504, 32'h508, 2'd0, 1'b0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
        drive(2'b11, 32'h600, 32'h604, 2'd1, 1'b1);
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_vld: got %b expected 00", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        drive(2'b11, 32'h700, 32'h704, 2'd0, 1'b0);
        tick();
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        reset_ = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rstmid_vld: got %b expected 00", out_valid); end
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        mq.delete();
        drive(2'b01, 32'h780, 32'h0, 2'd0, 1'b0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL rstmid_post_count: got %0d expected 1", count); end
        checks++; if (out_pc[31:0] !== 32'h780) begin errors++; $display("FAIL rstmid_post_pc: got %h expected 780", out_pc[31:0]); end
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
        tick();
    endtask

`ifdef FETCH_DEC_QUEUE_BYPASS_EN
    task automatic test_bypass();
        drive(2'b11, 32'h800, 32'h804, 2'd1, 1'b0);
        #2;
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL byp_vld: got %b expected 11", out_valid); end
        checks++; if (out_pc[31:0] !== 32'h800) begin errors++; $display("FAIL byp_pc0: got %h expected 800", out_pc[31:0]); end
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL byp_count: got %0d expected 1", count); end
        checks++; if (out_pc[31:0] !== 32'h804) begin errors++; $display("FAIL byp_held: got %h expected 804", out_pc[31:0]); end
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
        tick();
    endtask
`endif

    task automatic test_random();
        logic [1:0] v;
        logic [1:0] a;
        logic       f;
        int         maxa;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       v = 2'b00;
                1:       v = 2'b01;
                default: v = 2'b11;
            endcase
            f = ($urandom_range(0, 39) == 0);
            maxa = (mq.size() > 2) ? 2 : mq.size();
`ifdef FETCH_DEC_QUEUE_BYPASS_EN
            if (mq.size() == 0 && !f && v != 2'b00) maxa = int'(v[0]) + int'(v[1]);
`endif
            a = 2'($urandom_range(0, maxa));
            drive(v, $urandom, $urandom, a, f);
            #2;
            checks++; if (int'(count) !== mq.size()) begin errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, mq.size()); end
            checks++; if (in_ready !== (8 - mq.size() >= 2)) begin errors++; $display("FAIL rnd_ready c%0d: got %b", c, in_ready); end
            checks++; if (out_valid !== exp_vld()) begin errors++; $display("FAIL rnd_vld c%0d: got %b expected %b", c, out_valid, exp_vld()); end
            checks++; if (out_pc !== exp_pc()) begin errors++; $display("FAIL rnd_pc c%0d: got %h expected %h", c, out_pc, exp_pc()); end
            checks++; if (out_inst !== exp_inst()) begin errors++; $display("FAIL rnd_inst c%0d: got %h expected %h", c, out_inst, exp_inst()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_first_enqueue();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_reset_mid();
`ifdef FETCH_DEC_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_dec_queue.md
FETCH_DEC_QUEUE -- requirements
Module: fetch_dec_queue

Interface
REQ-001 SHALL have parameters: ADDR, `AddrWidth, PC width; INST, `InstWidth, instruction width; LANES, 2, max instructions per enqueue/dequeue cycle (1..4); DEPTH, 8, entries (power of two, >= 2*LANES).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- reset_  in  1  asynchronous active-low reset.
- in_valid  in  LANES  enqueue lane mask, contiguous from lane 0.
- in_pc  in  LANES*ADDR  per-lane PC.
- in_inst  in  LANES*INST  per-lane instruction.
- in_ready  out  1  queue accepts a full LANES group this cycle.
- out_valid  out  LANES  dequeue lane mask, contiguous from lane 0.
- out_pc  out  LANES*ADDR  per-lane PC, lane 0 = oldest.
- out_inst  out  LANES*INST  per-lane instruction.
- out_accept  in  $clog2(LANES+1)  number of oldest lanes consumed.
- flush  in  1  discard all entries.
- count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-003 SHALL store entries in a circular buffer with head/tail pointers of width $clog2(DEPTH), wrapping modulo DEPTH.
REQ-004 SHALL drive in_ready=1 iff (DEPTH - count) >= LANES; in_ready SHALL NOT depend on in_valid or out_accept.
REQ-005 SHALL, when in_ready=1 and popcount(in_valid)=k>0, write lanes 0..k-1 at tail..tail+k-1 and advance tail by k on the clock edge.
REQ-006 SHALL ignore in_valid when in_ready=0, with no state change from the enqueue side.
REQ-007 SHALL drive out_valid[i]=1 iff i < min(count, LANES); out_pc/out_inst lane i SHALL read entry head+i (mod DEPTH) combinationally.
REQ-008 SHALL, on out_accept=a, advance head by a and decrement count by a; a > popcount(out_valid) is illegal, with a simulation assertion.
REQ-009 SHALL update count as count + k - a when enqueue and dequeue occur in the same cycle, with wrap-around handled in both pointers.
REQ-010 SHALL give flush priority over enqueue and dequeue: head=tail=0 and count=0 at the next edge; same-cycle in_valid and out_accept are discarded.
REQ-011 SHALL have one-cycle enqueue-to-visible latency: data written at edge N appears on out_* after edge N (bypass disabled).
REQ-012 SHALL treat a non-contiguous in_valid mask as illegal, with a simulation assertion.
REQ-013 SHALL drive out_pc/out_inst lanes with out_valid=0 as don't-care, zero-filled.

Reset
REQ-014 SHALL, while reset_=0, asynchronously set head=0, tail=0, count=0, out_valid=0 and in_ready=1; storage contents are not reset.
REQ-015 SHALL, on reset_ asserted mid-operation, drop all entries; the first post-reset edge behaves as from empty.

Configuration
REQ-016 SHALL support macro FETCH_DEC_QUEUE_BYPASS_EN.
- Defined: when count=0, flush=0 and in_valid != 0, out_valid/out_pc/out_inst SHALL reflect in_* combinationally in the same cycle. Lanes accepted by out_accept SHALL NOT be written. The remaining lanes SHALL be written starting at head. count SHALL update by k - a.
- Undefined: REQ-011 latency holds and no input-to-output combinational path exists.

Verification
REQ-017 Bench (LANES=2, DEPTH=8) SHALL cover:
- Reset then enqueue in_valid=2'b11 with PCs 0x100, 0x104 -> next cycle out_valid=2'b11, out_pc lane0=0x100, count=2.
- Fill: four cycles of in_valid=2'b11 with out_accept=0 -> count=8; in_ready=0 from count=7; fifth group ignored.
- Wrap-around: steady in_valid=2'b01 with out_accept=1 for 20 cycles -> count stays 1, PCs emerge in order, pointers wrap past 7.
- Simultaneous: count=3, in_valid=2'b11, out_accept=2 -> count=3 next cycle, lane0 = former entry 2.
- Flush with in_valid=2'b11 and out_accept=1 at count=5 -> count=0, out_valid=0 next cycle; reset_ low mid-fill -> count=0 immediately.
- With FETCH_DEC_QUEUE_BYPASS_EN, empty queue, in_valid=2'b11, out_accept=1 -> same-cycle out_pc lane0=in_pc lane0, count=1 next cycle holding lane1.
